// File: rtl/dest_encoder.sv
// dest_encoder: picks one winner from a 16-line write-request vector and
// presents its register index plus one-hot enable on a valid/ready handshake.
// The grant is frozen until accepted.
//
// Compile-time option DEST_ENC_RR_EN:
//   defined   -> round-robin; the scan pointer moves past each accepted winner
//   undefined -> fixed priority; the lowest set request bit always wins
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant outstanding; valid=0, enable=0; req sampled each edge
// HOLD  | grant outstanding; dest/enable frozen until valid && ready
module dest_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      req,
  input  logic             ready,
  output logic             valid,
  output logic [3:0]       dest,
  output logic [15:0]      enable,
  output logic [CNT_W-1:0] grant_cnt
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [3:0]         dest_nxt;
  logic [15:0]        enable_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [3:0]         ptr;
  logic [3:0]         scan_idx;
  logic [3:0]         win_idx;
  logic               win_found;

`ifdef DEST_ENC_RR_EN
  logic [3:0]         ptr_nxt;

  // Pointer advances past the accepted winner so it drops to lowest priority.
  always_comb begin
    ptr_nxt = ptr;
    if (state == HOLD && ready) ptr_nxt = dest + 4'd1;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= 4'h0;
    else        ptr <= ptr_nxt;
  end
`else
  assign ptr = 4'h0;
`endif

  // First set request scanning upward from ptr, wrapping 15 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'h0;
    scan_idx  = 4'h0;
    for (int i = 0; i < 16; i++) begin
      scan_idx = ptr + 4'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state and next-output logic; HOLD ignores req entirely.
  always_comb begin
    state_nxt  = state;
    dest_nxt   = dest;
    enable_nxt = enable;
    cnt_nxt    = grant_cnt;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt  = HOLD;
          dest_nxt   = win_idx;
          enable_nxt = 16'h0001 << win_idx;
        end
      end
      HOLD: begin
        if (ready) begin
          state_nxt  = IDLE;
          enable_nxt = 16'h0000;
          cnt_nxt    = grant_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any in-flight grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dest      <= 4'h0;
      enable    <= 16'h0000;
      grant_cnt <= '0;
    end else begin
      state     <= state_nxt;
      dest      <= dest_nxt;
      enable    <= enable_nxt;
      grant_cnt <= cnt_nxt;
    end
  end

  assign valid = (state == HOLD);

endmodule

// File: tb/tb_dest_encoder.sv
// Directed testbench for dest_encoder; expectations follow DEST_ENC_RR_EN.
module tb_dest_encoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        ready;
  logic        valid;
  logic [3:0]  dest;
  logic [15:0] enable;
  logic [7:0]  grant_cnt;
  logic        valid2;
  logic [3:0]  dest2;
  logic [15:0] enable2;
  logic [1:0]  grant_cnt2;

  int checks   = 0;
  int failures = 0;

`ifdef DEST_ENC_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  dest_encoder #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
    .valid(valid), .dest(dest), .enable(enable), .grant_cnt(grant_cnt)
  );

  dest_encoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
    .valid(valid2), .dest(dest2), .enable(enable2), .grant_cnt(grant_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 16'h0000;
    ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (valid !== 1'b0 || dest !== 4'h0 || enable !== 16'h0000 || grant_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_idle: valid=%b dest=%0d enable=%h cnt=%0d, want 0/0/0000/0", valid, dest, enable, grant_cnt);
    end
    req = 16'h0080; ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1 || dest !== 4'd7 || grant_cnt !== 8'd1) begin
      failures++;
      $display("FAIL reset_pre_hold: valid=%b dest=%0d cnt=%0d, want 1/7/1", valid, dest, grant_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || dest !== 4'h0 || enable !== 16'h0000 || grant_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_async: valid=%b dest=%0d enable=%h cnt=%0d, want 0/0/0000/0", valid, dest, enable, grant_cnt);
    end
    req = 16'h0000; ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || enable !== 16'h0000 || grant_cnt !== 8'd0) begin
        failures++;
        $display("FAIL reset_stay_idle[%0d]: valid=%b enable=%h cnt=%0d, want 0/0000/0", c, valid, enable, grant_cnt);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 16'h0020; ready = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b1 || dest !== 4'd5 || enable !== 16'h0020) begin
      failures++;
      $display("FAIL single_grant: valid=%b dest=%0d enable=%h, want 1/5/0020", valid, dest, enable);
    end
    tick();
    req = 16'h0000;
    checks++;
    if (valid !== 1'b0 || enable !== 16'h0000 || grant_cnt !== 8'd1) begin
      failures++;
      $display("FAIL single_accept: valid=%b enable=%h cnt=%0d, want 0/0000/1", valid, enable, grant_cnt);
    end
    tick();
    checks++;
    if (valid !== 1'b0 || grant_cnt !== 8'd1) begin
      failures++;
      $display("FAIL single_bubble: valid=%b cnt=%0d, want 0/1", valid, grant_cnt);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    req = 16'h8000; ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) req = 16'h0001;
      checks++;
      if (valid !== 1'b1 || dest !== 4'd15 || enable !== 16'h8000 || grant_cnt !== 8'd0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b dest=%0d enable=%h cnt=%0d, want 1/15/8000/0", c, valid, dest, enable, grant_cnt);
      end
      tick();
    end
    ready = 1'b1;
    tick();
    req = 16'h0000; ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || enable !== 16'h0000 || grant_cnt !== 8'd1) begin
      failures++;
      $display("FAIL bp_accept: valid=%b enable=%h cnt=%0d, want 0/0000/1", valid, enable, grant_cnt);
    end
    tick();
    checks++;
    if (grant_cnt !== 8'd1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_count_once: valid=%b cnt=%0d, want 0/1", valid, grant_cnt);
    end
  endtask

  task automatic test_fairness();
    int g;
    logic [3:0] exp_dest;
    do_reset();
    req = 16'hFFFF; ready = 1'b1;
    g = 0;
    for (int t = 1; t <= 34; t++) begin
      tick();
      checks++;
      if (valid !== 1'(t % 2)) begin
        failures++;
        $display("FAIL fair_valid[%0d]: valid=%b, want %b", t, valid, 1'(t % 2));
      end
      if (t % 2 == 1) begin
        exp_dest = RR ? 4'(g % 16) : 4'd0;
        checks++;
        if (dest !== exp_dest || enable !== (16'h0001 << exp_dest)) begin
          failures++;
          $display("FAIL fair_dest[%0d]: dest=%0d enable=%h, want %0d", g, dest, enable, exp_dest);
        end
        g++;
      end
    end
    req = 16'h0000; ready = 1'b0;
    checks++;
    if (grant_cnt !== 8'd17) begin
      failures++;
      $display("FAIL fair_count: cnt=%0d, want 17", grant_cnt);
    end
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    req = 16'h8000; ready = 1'b1;
    tick();
    tick();
    req = 16'h8001;
    tick();
    checks++;
    if (valid !== 1'b1 || dest !== 4'd0) begin
      failures++;
      $display("FAIL wrap_first: valid=%b dest=%0d, want 1/0", valid, dest);
    end
    tick();
    tick();
    checks++;
    if (valid !== 1'b1 || dest !== (RR ? 4'd15 : 4'd0)) begin
      failures++;
      $display("FAIL wrap_second: valid=%b dest=%0d, want 1/%0d", valid, dest, RR ? 15 : 0);
    end
    tick();
    req = 16'h0000; ready = 1'b0;
  endtask

  task automatic test_counter_wrap();
    logic [1:0] exp2;
    do_reset();
    req = 16'h0001; ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      tick();
      exp2 = 2'(k);
      checks++;
      if (grant_cnt2 !== exp2 || grant_cnt !== 8'(k)) begin
        failures++;
        $display("FAIL cnt_wrap[%0d]: cnt2=%0d cnt8=%0d, want %0d/%0d", k, grant_cnt2, grant_cnt, exp2, k);
      end
    end
    req = 16'h0000; ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'h0000;
    ready = 1'b0;
    test_reset();
    test_single();
    test_back_pressure();
    test_fairness();
    test_ptr_wrap();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
